alu: RTL and testbench
======================

Name: alu

Overview:
- Registered WIDTH-bit arithmetic/logic unit with status flags: carry/borrow, zero and signed overflow.
- Inputs are sampled on each rising clock edge; results and flags appear on registered outputs one cycle later.
- Used as the datapath execution unit; any upstream stage may drive a new operation every cycle.

Parameters:
- WIDTH, 4, bit width of in_x, in_y and out_s (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- op  input  3  operation select.
- in_c  input  1  carry-in for ADD; borrow-in for SUB; ignored by all other ops.
- in_x  input  WIDTH  operand X (two's complement for signed ops).
- in_y  input  WIDTH  operand Y.
- out_s  output  WIDTH  registered result.
- out_c  output  1  registered carry-out (ADD) or borrow-out (SUB).
- zero  output  1  registered; 1 when out_s is all zeros.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a clock edge, out_s=0, out_c=0, overflow=0, zero=1.
  - Reset overrides the operation being computed in that cycle.
  - The first result appears on the first edge after rst_n returns to 1.
- Latency:
  - 1 cycle; a new op is accepted every cycle with no handshake.
  - Outputs hold their value until the next edge.
- Ops (all arithmetic is modulo 2^WIDTH):
  - 000 ADD: {out_c,out_s} = in_x + in_y + in_c. overflow=1 when in_x and in_y have equal MSBs and out_s MSB differs.
  - 001 SUB: out_s = in_x - in_y - in_c. out_c=1 (borrow) when unsigned in_x < unsigned in_y + in_c. overflow=1 when in_x and in_y MSBs differ and out_s MSB differs from in_x MSB.
  - 010 NOT: out_s = ~in_x.
  - 011 AND: out_s = in_x & in_y.
  - 100 OR: out_s = in_x | in_y.
  - 101 XOR: out_s = in_x ^ in_y.
  - 110 SLT: out_s = 1 if signed in_x < signed in_y, else 0. The comparison is exact; it is not derived from a truncated difference.
  - 111 EQ: out_s = 1 if in_x == in_y, else 0.
- Flags for ops 010–111: out_c=0 and overflow=0.
- zero is computed from the final out_s for every op, including SLT and EQ.
- Boundaries:
  - ADD of 0xF + 0x1 (WIDTH=4) wraps to 0 with out_c=1 and zero=1.
  - SUB of -8 minus 1 wraps to 7 with overflow=1.
  - in_c=1 with SUB of x-x gives all-ones with borrow=1.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: when overflow=1 on ADD or SUB, out_s is clamped instead of wrapping.
  - Clamp to the most positive signed value (0111…) if in_x is non-negative.
  - Clamp to the most negative signed value (1000…) otherwise.
  - overflow is still reported as 1; out_c is unchanged; zero reflects the clamped out_s.
- Undefined: plain modulo wrap as specified above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with op=000, x=3, y=4 -> out_s=0, out_c=0, overflow=0, zero=1. Release rst_n; next edge gives out_s=7.
- ADD, in_c=0: x=7, y=1 -> out_s=8, overflow=1, out_c=0, zero=0. x=F, y=1 -> out_s=0, out_c=1, overflow=0, zero=1. With ALU_SATURATE_EN, x=7, y=1 -> out_s=7, overflow=1.
- SUB: x=8(-8), y=1, in_c=0 -> out_s=7, overflow=1, out_c=0. x=3, y=5 -> out_s=E, out_c=1, overflow=0. x=5, y=5, in_c=1 -> out_s=F, out_c=1.
- Logic ops, x=C, y=A: NOT -> 3; AND -> 8; OR -> E; XOR -> 6. All with out_c=0 and overflow=0. x=F, y=0 with AND -> zero=1.
- SLT/EQ: SLT x=8(-8), y=7 -> 1. SLT x=7, y=8 -> 0 with zero=1. EQ x=5, y=5 -> 1 with zero=0.
- Exhaustive sweep: all 8 ops × x,y ∈ −8..7 × in_c ∈ {0,1}, changing inputs every cycle -> each output matches a reference model delayed by exactly one cycle.

Source files
------------

// File: rtl/alu.sv
// Registered WIDTH-bit ALU with carry/borrow, zero and signed-overflow flags.
// Define ALU_SATURATE_EN to clamp ADD/SUB results on signed overflow.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_t;

  localparam int MSB = WIDTH - 1;

  op_t op_q;
  assign op_q = op_t'(op);

  logic is_add;
  logic is_sub;
  logic is_not;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_slt;
  logic is_eq;

  assign is_add = (op_q == OP_ADD);
  assign is_sub = (op_q == OP_SUB);
  assign is_not = (op_q == OP_NOT);
  assign is_and = (op_q == OP_AND);
  assign is_or  = (op_q == OP_OR);
  assign is_xor = (op_q == OP_XOR);
  assign is_slt = (op_q == OP_SLT);
  assign is_eq  = (op_q == OP_EQ);

  // One extra bit holds carry-out (ADD) or borrow sign (SUB)
  logic [WIDTH:0] cin_ext;
  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;

  assign cin_ext  = {{WIDTH{1'b0}}, in_c};
  assign add_full = {1'b0, in_x} + {1'b0, in_y} + cin_ext;
  assign sub_full = {1'b0, in_x} - {1'b0, in_y} - cin_ext;

  logic add_ov;
  logic sub_ov;

  assign add_ov = (in_x[MSB] == in_y[MSB])
                & (add_full[MSB] != in_x[MSB]);
  assign sub_ov = (in_x[MSB] != in_y[MSB])
                & (sub_full[MSB] != in_x[MSB]);

  // Full signed compare, independent of the subtractor
  logic lt_s;
  logic eq_s;

  assign lt_s = ($signed(in_x) < $signed(in_y));
  assign eq_s = (in_x == in_y);

  logic [WIDTH-1:0] sat_val;

  assign sat_val = in_x[MSB]
                 ? {1'b1, {(WIDTH-1){1'b0}}}
                 : {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             ov_d;

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    ov_d  = 1'b0;
    unique case (1'b1)
      is_add: begin
        res_d = add_full[WIDTH-1:0];
        c_d   = add_full[WIDTH];
        ov_d  = add_ov;
      end
      is_sub: begin
        res_d = sub_full[WIDTH-1:0];
        c_d   = sub_full[WIDTH];
        ov_d  = sub_ov;
      end
      is_not: res_d = ~in_x;
      is_and: res_d = in_x & in_y;
      is_or:  res_d = in_x | in_y;
      is_xor: res_d = in_x ^ in_y;
      is_slt: res_d = {{(WIDTH-1){1'b0}}, lt_s};
      is_eq:  res_d = {{(WIDTH-1){1'b0}}, eq_s};
      default: res_d = '0;
    endcase
  end

  logic [WIDTH-1:0] fin_d;

`ifdef ALU_SATURATE_EN
  assign fin_d = ov_d ? sat_val : res_d;
`else
  assign fin_d = res_d;
  logic unused_sat;
  assign unused_sat = ^sat_val;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_s    <= '0;
      out_c    <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      out_s    <= fin_d;
      out_c    <= c_d;
      zero     <= ~|fin_d;
      overflow <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors, then a full
// op/operand/carry sweep checked against an integer model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] op;
  logic       in_c;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic [3:0] out_s;
  logic       out_c;
  logic       zero;
  logic       overflow;

  alu #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op(op),
    .in_c(in_c),
    .in_x(in_x),
    .in_y(in_y),
    .out_s(out_s),
    .out_c(out_c),
    .zero(zero),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  vld;
  int    n_cmp;
  int    n_bad;
  bit    done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic r, input logic [2:0] o,
                       input logic c, input logic [3:0] x,
                       input logic [3:0] y, input logic [3:0] es,
                       input logic ec, input logic ez,
                       input logic ev, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    op    = o;
    in_c  = c;
    in_x  = x;
    in_y  = y;
    vld   = 1'b1;
    e.s = es;
    e.c = ec;
    e.z = ez;
    e.v = ev;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  function automatic exp_t model(input int o, input int c,
                                 input int x, input int y);
    exp_t e;
    int xu, yu, r, sr;
    bit sat;
    xu = x & 15;
    yu = y & 15;
    e.c = 1'b0;
    e.v = 1'b0;
    sat = 1'b0;
    r = 0;
    case (o)
      0: begin
        r   = xu + yu + c;
        e.c = (r >= 16);
        sr  = x + y + c;
        e.v = (sr > 7) || (sr < -8);
      end
      1: begin
        r   = xu - yu - c;
        e.c = (r < 0);
        sr  = x - y - c;
        e.v = (sr > 7) || (sr < -8);
      end
      2: r = 15 - xu;
      3: r = xu & yu;
      4: r = xu | yu;
      5: r = xu ^ yu;
      6: r = (x < y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
`ifdef ALU_SATURATE_EN
    sat = e.v;
`endif
    if (sat) r = (x >= 0) ? 7 : 8;
    e.s = 4'(r & 15);
    e.z = (e.s == 4'd0);
    return e;
  endfunction

  // Monitor: one result is due on every edge that sampled a vector
  initial begin
    logic  v;
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(posedge clk);
      v = vld;
      #1;
      if (v) begin
        got = {out_s, out_c, zero, overflow};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL underflow: got result %h, required none", got);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got s=%h c=%b z=%b v=%b, required s=%h c=%b z=%b v=%b",
                     nm, got.s, got.c, got.z, got.v, e.s, e.c, e.z, e.v);
          end
        end
      end
    end
  end

  initial begin
    exp_t m;
    logic [3:0] sat_a;
    logic [3:0] sat_b;
    n_cmp = 0;
    n_bad = 0;
    done  = 1'b0;
    vld   = 1'b0;
    rst_n = 1'b0;
    op    = 3'b000;
    in_c  = 1'b0;
    in_x  = 4'h0;
    in_y  = 4'h0;
`ifdef ALU_SATURATE_EN
    sat_a = 4'h7;
    sat_b = 4'h8;
`else
    sat_a = 4'h8;
    sat_b = 4'h7;
`endif
    issue(0, 3'b000, 0, 4'h3, 4'h4, 4'h0, 0, 1, 0, "rst0");
    issue(0, 3'b000, 0, 4'h3, 4'h4, 4'h0, 0, 1, 0, "rst1");
    issue(1, 3'b000, 0, 4'h3, 4'h4, 4'h7, 0, 0, 0, "rel_add");
    issue(1, 3'b000, 0, 4'h7, 4'h1, sat_a, 0, 0, 1, "add_ov");
    issue(1, 3'b000, 0, 4'hF, 4'h1, 4'h0, 1, 1, 0, "add_wrap");
    issue(1, 3'b000, 1, 4'hE, 4'h1, 4'h0, 1, 1, 0, "add_cin");
    issue(1, 3'b001, 0, 4'h8, 4'h1, sat_b, 0, 0, 1, "sub_ov");
    issue(1, 3'b001, 0, 4'h3, 4'h5, 4'hE, 1, 0, 0, "sub_brw");
    issue(1, 3'b001, 1, 4'h5, 4'h5, 4'hF, 1, 0, 0, "sub_bin");
    issue(1, 3'b010, 1, 4'hC, 4'hA, 4'h3, 0, 0, 0, "not");
    issue(1, 3'b011, 1, 4'hC, 4'hA, 4'h8, 0, 0, 0, "and");
    issue(1, 3'b100, 0, 4'hC, 4'hA, 4'hE, 0, 0, 0, "or");
    issue(1, 3'b101, 0, 4'hC, 4'hA, 4'h6, 0, 0, 0, "xor");
    issue(1, 3'b011, 0, 4'hF, 4'h0, 4'h0, 0, 1, 0, "and_zero");
    issue(1, 3'b110, 0, 4'h8, 4'h7, 4'h1, 0, 0, 0, "slt_neg");
    issue(1, 3'b110, 0, 4'h7, 4'h8, 4'h0, 0, 1, 0, "slt_pos");
    issue(1, 3'b111, 1, 4'h5, 4'h5, 4'h1, 0, 0, 0, "eq");
    issue(0, 3'b001, 1, 4'h5, 4'h5, 4'h0, 0, 1, 0, "rst_mid");
    for (int o = 0; o < 8; o++)
      for (int x = -8; x < 8; x++)
        for (int y = -8; y < 8; y++)
          for (int c = 0; c < 2; c++) begin
            m = model(o, c, x, y);
            issue(1, 3'(o), 1'(c), 4'(x), 4'(y),
                  m.s, m.c, m.z, m.v, $sformatf("sw%0d_%0d_%0d_%0d", o, x, y, c));
          end
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
